fp_instr_decoder: RTL and testbench

Pipelined floating-point instruction decoder for the F/D extension, parametrised by floating-point mode. It sits between the integer decode stage and the FPU issue logic. It accepts 32-bit instructions over a valid/ready handshake and classifies the FP opcodes (LOAD_FP, STORE_FP, MADD/MSUB/NMSUB/NMADD, OP_FP). It emits a registered decoded bundle through a 2-entry skid buffer, so backpressure never creates a combinational ready path.

---
 rtl/fp_instr_decoder.sv | 249 ++++++++++++++++++++++++
 tb/tb_fp_instr_decoder.sv | 342 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fp_instr_decoder.sv
// F/D-extension instruction decoder with a registered output stage and one skid entry.
// Optional FP_ILLEGAL_CNT_EN adds a saturating 16-bit count of accepted illegal FP instructions.
module fp_instr_decoder #(
   parameter int unsigned RVF = 1
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        flush_i,
   input  logic        in_valid_i,
   output logic        in_ready_o,
   input  logic [31:0] instr_i,
   input  logic [2:0]  frm_i,
   output logic        out_valid_o,
   input  logic        out_ready_i,
   output logic        is_fp_o,
   output logic        illegal_o,
   output logic [4:0]  op_o,
   output logic        fmt_o,
   output logic [2:0]  rm_o,
   output logic [4:0]  rs1_o,
   output logic [4:0]  rs2_o,
   output logic [4:0]  rs3_o,
   output logic [4:0]  rd_o,
   output logic        use_rs3_o,
   output logic [15:0] illegal_cnt_o
);

   localparam bit HAS_F = (RVF != 0);
   localparam bit HAS_D = (RVF == 2);

   localparam logic [4:0] OP_LOAD     = 5'd0;
   localparam logic [4:0] OP_STORE    = 5'd1;
   localparam logic [4:0] OP_MADD     = 5'd2;
   localparam logic [4:0] OP_ADD      = 5'd6;
   localparam logic [4:0] OP_SUB      = 5'd7;
   localparam logic [4:0] OP_MUL      = 5'd8;
   localparam logic [4:0] OP_DIV      = 5'd9;
   localparam logic [4:0] OP_SQRT     = 5'd10;
   localparam logic [4:0] OP_SGNJ     = 5'd11;
   localparam logic [4:0] OP_MINMAX   = 5'd12;
   localparam logic [4:0] OP_CMP      = 5'd13;
   localparam logic [4:0] OP_CVT_F2I  = 5'd14;
   localparam logic [4:0] OP_CVT_I2F  = 5'd15;
   localparam logic [4:0] OP_CVT_F2F  = 5'd16;
   localparam logic [4:0] OP_MV_F2X   = 5'd17;
   localparam logic [4:0] OP_CLASS    = 5'd18;
   localparam logic [4:0] OP_MV_X2F   = 5'd19;
   localparam logic [4:0] OP_NONE     = 5'd31;

   typedef struct packed {
      logic       is_fp;
      logic       illegal;
      logic [4:0] op;
      logic       fmt;
      logic [2:0] rm;
      logic [4:0] rs1;
      logic [4:0] rs2;
      logic [4:0] rs3;
      logic [4:0] rd;
      logic       use_rs3;
   } bundle_t;

   bundle_t    dec;
   bundle_t    out_q;
   bundle_t    skid_q;
   logic       out_valid_q;
   logic       skid_valid_q;
   logic       accept;
   logic       out_free;

   logic [6:0] opc;
   logic [2:0] f3;
   logic [4:0] f5;
   logic [1:0] fmt2;
   logic [4:0] rs2;
   logic [4:0] op_cls;
   logic       legal;
   logic       chk_rm;
   logic       fused;
   logic       fmt_bit;
   logic       ls_op;
   logic [2:0] rm_res;

   always_comb begin
      opc     = instr_i[6:0];
      f3      = instr_i[14:12];
      f5      = instr_i[31:27];
      fmt2    = instr_i[26:25];
      rs2     = instr_i[24:20];
      op_cls  = OP_NONE;
      legal   = 1'b1;
      chk_rm  = 1'b0;
      fused   = 1'b0;
      ls_op   = 1'b0;
      fmt_bit = fmt2[0];
      rm_res  = f3;
      dec     = '0;
      dec.is_fp = 1'b1;

      case (opc)
         7'b0000111, 7'b0100111: begin
            ls_op   = 1'b1;
            op_cls  = opc[5] ? OP_STORE : OP_LOAD;
            fmt_bit = f3[0];
            legal   = (f3 == 3'b010) || (f3 == 3'b011);
         end
         7'b1000011, 7'b1000111, 7'b1001011, 7'b1001111: begin
            fused  = 1'b1;
            chk_rm = 1'b1;
            op_cls = OP_MADD + {3'b000, opc[3:2]};
         end
         7'b1010011: begin
            case (f5)
               5'b00000: begin op_cls = OP_ADD; chk_rm = 1'b1; end
               5'b00001: begin op_cls = OP_SUB; chk_rm = 1'b1; end
               5'b00010: begin op_cls = OP_MUL; chk_rm = 1'b1; end
               5'b00011: begin op_cls = OP_DIV; chk_rm = 1'b1; end
               5'b01011: begin
                  op_cls = OP_SQRT;
                  chk_rm = 1'b1;
                  legal  = (rs2 == 5'd0);
               end
               5'b00100: begin op_cls = OP_SGNJ;   legal = (f3 <= 3'd2); end
               5'b00101: begin op_cls = OP_MINMAX; legal = (f3 <= 3'd1); end
               5'b10100: begin op_cls = OP_CMP;    legal = (f3 <= 3'd2); end
               5'b11000: begin
                  op_cls = OP_CVT_F2I;
                  chk_rm = 1'b1;
                  legal  = (rs2 <= 5'd1);
               end
               5'b11010: begin
                  op_cls = OP_CVT_I2F;
                  chk_rm = 1'b1;
                  legal  = (rs2 <= 5'd1);
               end
               5'b01000: begin
                  op_cls = OP_CVT_F2F;
                  chk_rm = 1'b1;
                  legal  = HAS_D && (rs2 == {4'b0000, ~fmt2[0]});
               end
               5'b11100: begin
                  if (f3 == 3'b000) begin
                     op_cls = OP_MV_F2X;
                     legal  = (rs2 == 5'd0) && (fmt2 == 2'b00);
                  end else if (f3 == 3'b001) begin
                     op_cls = OP_CLASS;
                     legal  = (rs2 == 5'd0);
                  end else begin
                     legal  = 1'b0;
                  end
               end
               5'b11110: begin
                  op_cls = OP_MV_X2F;
                  legal  = (f3 == 3'b000) && (rs2 == 5'd0) && (fmt2 == 2'b00);
               end
               default: legal = 1'b0;
            endcase
         end
         default: dec.is_fp = 1'b0;
      endcase

      // Double-width operands need the D extension; fmt 10/11 are reserved.
      if (!ls_op && fmt2[1])
         legal = 1'b0;
      if (fmt_bit && !HAS_D)
         legal = 1'b0;
      if (!HAS_F)
         legal = 1'b0;

      if (chk_rm) begin
         if (f3 == 3'b101 || f3 == 3'b110)
            legal = 1'b0;
         if (f3 == 3'b111) begin
            rm_res = frm_i;
            if (frm_i >= 3'b101)
               legal = 1'b0;
         end
      end

      dec.illegal = dec.is_fp && !legal;
      dec.op      = (dec.is_fp && legal) ? op_cls : OP_NONE;
      dec.use_rs3 = dec.is_fp && legal && fused;
      dec.fmt     = fmt_bit;
      dec.rm      = rm_res;
      dec.rs1     = instr_i[19:15];
      dec.rs2     = rs2;
      dec.rs3     = f5;
      dec.rd      = instr_i[11:7];
   end

   assign in_ready_o = !skid_valid_q;
   assign accept     = in_valid_i && !skid_valid_q;
   assign out_free   = !out_valid_q || out_ready_i;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         out_valid_q  <= 1'b0;
         skid_valid_q <= 1'b0;
         out_q        <= '0;
         skid_q       <= '0;
      end else if (flush_i) begin
         out_valid_q  <= 1'b0;
         skid_valid_q <= 1'b0;
      end else if (out_free) begin
         // A valid skid entry implies in_ready was low, so nothing new arrives this cycle.
         if (skid_valid_q) begin
            out_q        <= skid_q;
            out_valid_q  <= 1'b1;
            skid_valid_q <= 1'b0;
         end else if (accept) begin
            out_q       <= dec;
            out_valid_q <= 1'b1;
         end else begin
            out_valid_q <= 1'b0;
         end
      end else if (accept) begin
         skid_q       <= dec;
         skid_valid_q <= 1'b1;
      end
   end

`ifdef FP_ILLEGAL_CNT_EN
   logic [15:0] illegal_cnt_q;

   always_ff @(posedge clk_i) begin
      if (rst_i)
         illegal_cnt_q <= '0;
      else if (accept && !flush_i && dec.illegal && illegal_cnt_q != 16'hFFFF)
         illegal_cnt_q <= illegal_cnt_q + 16'd1;
   end

   assign illegal_cnt_o = illegal_cnt_q;
`else
   assign illegal_cnt_o = '0;
`endif

   assign out_valid_o = out_valid_q;
   assign is_fp_o     = out_q.is_fp;
   assign illegal_o   = out_q.illegal;
   assign op_o        = out_q.op;
   assign fmt_o       = out_q.fmt;
   assign rm_o        = out_q.rm;
   assign rs1_o       = out_q.rs1;
   assign rs2_o       = out_q.rs2;
   assign rs3_o       = out_q.rs3;
   assign rd_o        = out_q.rd;
   assign use_rs3_o   = out_q.use_rs3;

endmodule

// File: tb/tb_fp_instr_decoder.sv
// Directed bench for fp_instr_decoder: three instances (RVF 0/1/2) share one stimulus stream.
module tb_fp_instr_decoder;

   localparam logic [6:0] OPF  = 7'b1010011;
   localparam logic [6:0] LDF  = 7'b0000111;
   localparam logic [6:0] STF  = 7'b0100111;
   localparam logic [6:0] MADD = 7'b1000011;
   localparam logic [6:0] NMAD = 7'b1001111;

`ifdef FP_ILLEGAL_CNT_EN
   localparam bit CNT_EN = 1'b1;
`else
   localparam bit CNT_EN = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        flush = 1'b0;
   logic        in_valid = 1'b0;
   logic [31:0] instr = '0;
   logic [2:0]  frm = '0;
   logic        out_ready = 1'b1;

   logic        in_ready [3];
   logic        out_valid[3];
   logic        is_fp    [3];
   logic        illegal  [3];
   logic [4:0]  op       [3];
   logic        fmt      [3];
   logic [2:0]  rm       [3];
   logic [4:0]  rs1      [3];
   logic [4:0]  rs2      [3];
   logic [4:0]  rs3      [3];
   logic [4:0]  rd       [3];
   logic        use_rs3  [3];
   logic [15:0] cnt      [3];

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   for (genvar g = 0; g < 3; g++) begin : g_dut
      fp_instr_decoder #(.RVF(g)) u_dut (
         .clk_i         (clk),
         .rst_i         (rst),
         .flush_i       (flush),
         .in_valid_i    (in_valid),
         .in_ready_o    (in_ready[g]),
         .instr_i       (instr),
         .frm_i         (frm),
         .out_valid_o   (out_valid[g]),
         .out_ready_i   (out_ready),
         .is_fp_o       (is_fp[g]),
         .illegal_o     (illegal[g]),
         .op_o          (op[g]),
         .fmt_o         (fmt[g]),
         .rm_o          (rm[g]),
         .rs1_o         (rs1[g]),
         .rs2_o         (rs2[g]),
         .rs3_o         (rs3[g]),
         .rd_o          (rd[g]),
         .use_rs3_o     (use_rs3[g]),
         .illegal_cnt_o (cnt[g])
      );
   end

   typedef struct {
      logic [31:0] ins;
      logic [2:0]  frm;
      logic        is_fp;
      logic [4:0]  op1;
      logic [4:0]  op2;
      logic        fmt;
      logic [2:0]  rm;
   } vec_t;

   vec_t vt[$];

   function automatic logic [31:0] enc(input logic [4:0] f5, input logic [1:0] fm,
                                       input logic [4:0] r2, input logic [4:0] r1,
                                       input logic [2:0] f3, input logic [4:0] rdi,
                                       input logic [6:0] opc);
      return {f5, fm, r2, r1, f3, rdi, opc};
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic add(input logic [31:0] ins, input logic [2:0] f, input logic fp,
                      input logic [4:0] o1, input logic [4:0] o2,
                      input logic fm, input logic [2:0] r);
      vec_t v;
      v.ins = ins; v.frm = f; v.is_fp = fp; v.op1 = o1; v.op2 = o2; v.fmt = fm; v.rm = r;
      vt.push_back(v);
   endtask

   task automatic issue(input logic [31:0] ins, input logic [2:0] f);
      instr     = ins;
      frm       = f;
      in_valid  = 1'b1;
      out_ready = 1'b1;
      step();
      in_valid  = 1'b0;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      step();
      step();
      rst = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      in_valid = 1'b1;
      instr = 32'h02A5F553;
      out_ready = 1'b0;
      step();
      step();
      total++;
      if (out_valid[1] !== 1'b0) begin bad++; $display("FAIL reset_out_valid got=%0d want=0", out_valid[1]); end
      total++;
      if (in_ready[1] !== 1'b1) begin bad++; $display("FAIL reset_in_ready got=%0d want=1", in_ready[1]); end
      total++;
      if (op[1] !== 5'd0 || illegal[1] !== 1'b0 || rd[1] !== 5'd0 || is_fp[1] !== 1'b0)
         begin bad++; $display("FAIL reset_bundle op=%0d ill=%0d rd=%0d isfp=%0d want all 0", op[1], illegal[1], rd[1], is_fp[1]); end
      total++;
      if (cnt[1] !== 16'd0) begin bad++; $display("FAIL reset_cnt got=%0d want=0", cnt[1]); end
      in_valid = 1'b0;
      out_ready = 1'b1;
      rst = 1'b0;
   endtask

   task automatic test_fadd_fields();
      issue(32'h00A5F553, 3'b000);
      total++;
      if (out_valid[1] !== 1'b1 || op[1] !== 5'd6 || fmt[1] !== 1'b0 || rm[1] !== 3'b000 || illegal[1] !== 1'b0)
         begin bad++; $display("FAIL fadd_s v=%0d op=%0d fmt=%0d rm=%0d ill=%0d want 1/6/0/0/0", out_valid[1], op[1], fmt[1], rm[1], illegal[1]); end
      total++;
      if (rd[1] !== 5'd10 || rs1[1] !== 5'd11 || rs2[1] !== 5'd10 || rs3[1] !== 5'd0 || use_rs3[1] !== 1'b0)
         begin bad++; $display("FAIL fadd_regs rd=%0d rs1=%0d rs2=%0d rs3=%0d u3=%0d want 10/11/10/0/0", rd[1], rs1[1], rs2[1], rs3[1], use_rs3[1]); end
      step();
      total++;
      if (out_valid[1] !== 1'b0) begin bad++; $display("FAIL fadd_drain got=%0d want=0", out_valid[1]); end
      issue(enc(5'd3, 2'b00, 5'd2, 5'd1, 3'b000, 5'd4, MADD), 3'b000);
      total++;
      if (op[1] !== 5'd2 || use_rs3[1] !== 1'b1 || rs3[1] !== 5'd3 || rd[1] !== 5'd4)
         begin bad++; $display("FAIL fmadd op=%0d u3=%0d rs3=%0d rd=%0d want 2/1/3/4", op[1], use_rs3[1], rs3[1], rd[1]); end
      issue(32'h02A5F553, 3'b000);
      total++;
      if (illegal[1] !== 1'b1 || op[1] !== 5'd31 || rd[1] !== 5'd10 || use_rs3[1] !== 1'b0)
         begin bad++; $display("FAIL illegal_regs ill=%0d op=%0d rd=%0d u3=%0d want 1/31/10/0", illegal[1], op[1], rd[1], use_rs3[1]); end
   endtask

   task automatic test_decode_table();
      logic [4:0] e;
      logic       ei;
      vt.delete();
      add(32'h00A5F553, 3'b000, 1,  6,  6, 0, 3'b000);
      add(32'h02A5F553, 3'b000, 1, 31,  6, 1, 3'b000);
      add(32'h10A5F553, 3'b101, 1, 31, 31, 0, 3'b101);
      add(32'h10A5F553, 3'b001, 1,  8,  8, 0, 3'b001);
      add(enc(5'b00000, 2'b00, 5'd2, 5'd1, 3'b101, 5'd3, OPF), 3'b000, 1, 31, 31, 0, 3'b101);
      add(enc(5'b00100, 2'b00, 5'd2, 5'd1, 3'b010, 5'd3, OPF), 3'b111, 1, 11, 11, 0, 3'b010);
      add(enc(5'b00100, 2'b00, 5'd2, 5'd1, 3'b011, 5'd3, OPF), 3'b000, 1, 31, 31, 0, 3'b011);
      add(enc(5'b01011, 2'b00, 5'd1, 5'd1, 3'b000, 5'd2, OPF), 3'b000, 1, 31, 31, 0, 3'b000);
      add(enc(5'b01011, 2'b00, 5'd0, 5'd1, 3'b000, 5'd2, OPF), 3'b000, 1, 10, 10, 0, 3'b000);
      add(enc(5'b11100, 2'b00, 5'd0, 5'd1, 3'b000, 5'd2, OPF), 3'b000, 1, 17, 17, 0, 3'b000);
      add(enc(5'b11100, 2'b01, 5'd0, 5'd1, 3'b000, 5'd2, OPF), 3'b000, 1, 31, 31, 1, 3'b000);
      add(enc(5'b11100, 2'b01, 5'd0, 5'd1, 3'b001, 5'd2, OPF), 3'b000, 1, 31, 18, 1, 3'b001);
      add(enc(5'b01000, 2'b01, 5'd0, 5'd1, 3'b000, 5'd2, OPF), 3'b000, 1, 31, 16, 1, 3'b000);
      add(enc(5'b01000, 2'b00, 5'd1, 5'd1, 3'b000, 5'd2, OPF), 3'b000, 1, 31, 16, 0, 3'b000);
      add(enc(5'd3, 2'b00, 5'd2, 5'd1, 3'b111, 5'd4, NMAD),      3'b010, 1,  5,  5, 0, 3'b010);
      add(enc(5'd0, 2'b00, 5'd0, 5'd1, 3'b010, 5'd2, LDF),       3'b000, 1,  0,  0, 0, 3'b010);
      add(enc(5'd0, 2'b00, 5'd0, 5'd1, 3'b011, 5'd2, LDF),       3'b000, 1, 31,  0, 1, 3'b011);
      add(enc(5'd0, 2'b00, 5'd2, 5'd1, 3'b010, 5'd4, STF),       3'b000, 1,  1,  1, 0, 3'b010);
      add(enc(5'd0, 2'b00, 5'd0, 5'd1, 3'b001, 5'd2, LDF),       3'b000, 1, 31, 31, 0, 3'b001);
      add(32'h00000013, 3'b000, 0, 31, 31, 0, 3'b000);
      add(enc(5'b00101, 2'b00, 5'd2, 5'd1, 3'b000, 5'd3, OPF), 3'b000, 1, 12, 12, 0, 3'b000);
      add(enc(5'b00101, 2'b00, 5'd2, 5'd1, 3'b010, 5'd3, OPF), 3'b000, 1, 31, 31, 0, 3'b010);
      add(enc(5'b11000, 2'b00, 5'd0, 5'd1, 3'b001, 5'd3, OPF), 3'b000, 1, 14, 14, 0, 3'b001);
      add(enc(5'b11010, 2'b00, 5'd1, 5'd1, 3'b000, 5'd3, OPF), 3'b000, 1, 15, 15, 0, 3'b000);
      add(enc(5'b11000, 2'b00, 5'd2, 5'd1, 3'b000, 5'd3, OPF), 3'b000, 1, 31, 31, 0, 3'b000);
      add(enc(5'b10100, 2'b00, 5'd2, 5'd1, 3'b010, 5'd3, OPF), 3'b000, 1, 13, 13, 0, 3'b010);
      add(enc(5'b11110, 2'b00, 5'd0, 5'd1, 3'b000, 5'd3, OPF), 3'b000, 1, 19, 19, 0, 3'b000);
      add(enc(5'b11111, 2'b00, 5'd0, 5'd1, 3'b000, 5'd3, OPF), 3'b000, 1, 31, 31, 0, 3'b000);
      add(enc(5'b00000, 2'b10, 5'd2, 5'd1, 3'b000, 5'd3, OPF), 3'b000, 1, 31, 31, 0, 3'b000);
      foreach (vt[i]) begin
         issue(vt[i].ins, vt[i].frm);
         for (int g = 0; g < 3; g++) begin
            e  = (g == 0) ? 5'd31 : (g == 1) ? vt[i].op1 : vt[i].op2;
            ei = vt[i].is_fp && (e == 5'd31);
            total++;
            if (out_valid[g] !== 1'b1 || op[g] !== e || illegal[g] !== ei || is_fp[g] !== vt[i].is_fp)
               begin bad++; $display("FAIL dec[%0d] rvf=%0d v=%0d op=%0d ill=%0d fp=%0d want 1/%0d/%0d/%0d", i, g, out_valid[g], op[g], illegal[g], is_fp[g], e, ei, vt[i].is_fp); end
            if (e != 5'd31) begin
               total++;
               if (fmt[g] !== vt[i].fmt || rm[g] !== vt[i].rm || use_rs3[g] !== (e >= 5'd2 && e <= 5'd5))
                  begin bad++; $display("FAIL dec_fmt_rm[%0d] rvf=%0d fmt=%0d rm=%0d u3=%0d want %0d/%0d/%0d", i, g, fmt[g], rm[g], use_rs3[g], vt[i].fmt, vt[i].rm, (e >= 5'd2 && e <= 5'd5)); end
            end
         end
      end
      step();
   endtask

   task automatic test_backpressure();
      do_reset();
      out_ready = 1'b0;
      in_valid  = 1'b1;
      instr = enc(5'd0, 2'b00, 5'd2, 5'd1, 3'b000, 5'd1, OPF);
      step();
      instr = enc(5'd0, 2'b00, 5'd2, 5'd1, 3'b000, 5'd2, OPF);
      step();
      instr = enc(5'd0, 2'b00, 5'd2, 5'd1, 3'b000, 5'd3, OPF);
      total++;
      if (in_ready[1] !== 1'b0) begin bad++; $display("FAIL bp_in_ready_full got=%0d want=0", in_ready[1]); end
      step();
      step();
      total++;
      if (out_valid[1] !== 1'b1 || rd[1] !== 5'd1 || in_ready[1] !== 1'b0)
         begin bad++; $display("FAIL bp_hold v=%0d rd=%0d rdy=%0d want 1/1/0", out_valid[1], rd[1], in_ready[1]); end
      out_ready = 1'b1;
      step();
      total++;
      if (out_valid[1] !== 1'b1 || rd[1] !== 5'd2 || in_ready[1] !== 1'b1)
         begin bad++; $display("FAIL bp_second v=%0d rd=%0d rdy=%0d want 1/2/1", out_valid[1], rd[1], in_ready[1]); end
      step();
      in_valid = 1'b0;
      total++;
      if (out_valid[1] !== 1'b1 || rd[1] !== 5'd3)
         begin bad++; $display("FAIL bp_third v=%0d rd=%0d want 1/3", out_valid[1], rd[1]); end
      step();
      total++;
      if (out_valid[1] !== 1'b0) begin bad++; $display("FAIL bp_empty got=%0d want=0", out_valid[1]); end
   endtask

   task automatic test_back_to_back();
      out_ready = 1'b1;
      in_valid  = 1'b1;
      for (int k = 1; k <= 6; k++) begin
         instr = enc(5'd0, 2'b00, 5'd2, 5'd1, 3'b000, 5'(k + 8), OPF);
         step();
         total++;
         if (out_valid[1] !== 1'b1 || rd[1] !== 5'(k + 8) || in_ready[1] !== 1'b1)
            begin bad++; $display("FAIL b2b[%0d] v=%0d rd=%0d rdy=%0d want 1/%0d/1", k, out_valid[1], rd[1], in_ready[1], k + 8); end
      end
      in_valid = 1'b0;
      step();
   endtask

   task automatic test_flush();
      logic [15:0] c0;
      do_reset();
      out_ready = 1'b0;
      in_valid  = 1'b1;
      instr = enc(5'd0, 2'b00, 5'd2, 5'd1, 3'b000, 5'd1, OPF);
      step();
      c0 = cnt[1];
      instr = 32'h02A5F553;
      flush = 1'b1;
      step();
      flush = 1'b0;
      in_valid = 1'b0;
      total++;
      if (out_valid[1] !== 1'b0 || in_ready[1] !== 1'b1 || cnt[1] !== c0)
         begin bad++; $display("FAIL flush_one v=%0d rdy=%0d cnt=%0d want 0/1/%0d", out_valid[1], in_ready[1], cnt[1], c0); end
      in_valid = 1'b1;
      instr = enc(5'd0, 2'b00, 5'd2, 5'd1, 3'b000, 5'd1, OPF);
      step();
      instr = enc(5'd0, 2'b00, 5'd2, 5'd1, 3'b000, 5'd2, OPF);
      step();
      total++;
      if (in_ready[1] !== 1'b0) begin bad++; $display("FAIL flush_prefill rdy=%0d want=0", in_ready[1]); end
      instr = 32'h02A5F553;
      flush = 1'b1;
      step();
      flush = 1'b0;
      in_valid = 1'b0;
      total++;
      if (out_valid[1] !== 1'b0 || in_ready[1] !== 1'b1 || cnt[1] !== c0)
         begin bad++; $display("FAIL flush_full v=%0d rdy=%0d cnt=%0d want 0/1/%0d", out_valid[1], in_ready[1], cnt[1], c0); end
      out_ready = 1'b1;
      step();
      total++;
      if (out_valid[1] !== 1'b0) begin bad++; $display("FAIL flush_after v=%0d want=0", out_valid[1]); end
   endtask

   task automatic test_illegal_cnt();
      do_reset();
      out_ready = 1'b1;
      for (int k = 0; k < 3; k++) issue(32'h02A5F553, 3'b000);
      issue(32'h00A5F553, 3'b000);
      step();
      total++;
      if (cnt[1] !== (CNT_EN ? 16'd3 : 16'd0))
         begin bad++; $display("FAIL cnt_basic got=%0d want=%0d", cnt[1], CNT_EN ? 3 : 0); end
      total++;
      if (cnt[2] !== 16'd0) begin bad++; $display("FAIL cnt_rvf2_legal got=%0d want=0", cnt[2]); end
`ifdef FP_ILLEGAL_CNT_EN
      in_valid = 1'b1;
      instr = 32'h02A5F553;
      repeat (65531) @(posedge clk);
      #1;
      total++;
      if (cnt[1] !== 16'hFFFE) begin bad++; $display("FAIL cnt_near_sat got=%0h want=fffe", cnt[1]); end
      step();
      step();
      total++;
      if (cnt[1] !== 16'hFFFF) begin bad++; $display("FAIL cnt_sat got=%0h want=ffff", cnt[1]); end
      step();
      total++;
      if (cnt[1] !== 16'hFFFF) begin bad++; $display("FAIL cnt_sat_hold got=%0h want=ffff", cnt[1]); end
      rst = 1'b1;
      step();
      total++;
      if (cnt[1] !== 16'd0 || out_valid[1] !== 1'b0)
         begin bad++; $display("FAIL cnt_rst cnt=%0h v=%0d want 0/0", cnt[1], out_valid[1]); end
      rst = 1'b0;
      step();
      in_valid = 1'b0;
      total++;
      if (cnt[1] !== 16'd1 || out_valid[1] !== 1'b1)
         begin bad++; $display("FAIL cnt_after_rst cnt=%0h v=%0d want 1/1", cnt[1], out_valid[1]); end
`endif
   endtask

   initial begin
      test_reset();
      test_fadd_fields();
      test_decode_table();
      test_backpressure();
      test_back_to_back();
      test_flush();
      test_illegal_cnt();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
